// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams a contiguous range of data-memory words out on a
// valid/ready handshake. Each word takes READ (strobe), WAIT (capture) and
// HOLD (present until accepted). Addresses wrap modulo 2^ADDR_W.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN builds a running 32-bit
// wrap-around sum of every accepted word; without it checksum is tied to 0.
module mem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  // A word is consumed only while presented in HOLD (out_valid is high there only)
  logic w_hs;
  assign w_hs = (r_state == S_HOLD) && out_ready;

  // Word-sequencing FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_rd_en     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (count != '0) begin
              r_addr      <= base_addr;
              r_remaining <= count;
              r_rd_en     <= 1'b1;
              r_state     <= S_READ;
            end else begin
              // empty dump: still report completion, no memory traffic
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // memory answers one cycle after the strobe
          r_out_data  <= mem_rd_data;
          r_out_last  <= (r_remaining == (ADDR_W+1)'(1));
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_remaining <= r_remaining - 1'b1;
            r_addr      <= r_addr + 1'b1;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rd_en     <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running sum: cleared on an accepted start, bumped by each accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a 1-cycle-latency memory model.
module tb_mem_dump_reader;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  mem_dump_reader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  logic [31:0] words[$];
  logic        lasts[$];
  logic [9:0]  rdaddrs[$];
  int          done_cnt, done_cyc, first_valid, stall_bad, finished;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a one-cycle start; returns at the negedge of the cycle after acceptance
  task automatic do_start(input int b, input int c);
    @(negedge clk);
    start = 1'b1; base_addr = 10'(b); count = 11'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample at negedges, drive out_ready for the next edge, record handshaken words.
  // stall_idx/stall_len: hold ready low on that word; stop_idx: return while holding it.
  task automatic collect(input int stall_idx, input int stall_len, input int stop_idx);
    int hs, left;
    logic [31:0] held;
    logic pv, phs;
    hs = 0; left = stall_len; held = '0; pv = 1'b0; phs = 1'b0;
    words.delete(); lasts.delete(); rdaddrs.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; stall_bad = 0; finished = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (pv && !phs && !out_valid) stall_bad++;
      phs = 1'b0;
      if (mem_rd_en) rdaddrs.push_back(mem_addr);
      if (done) begin
        done_cnt++; done_cyc = cyc; finished = 1;
        @(negedge clk);
        return;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (hs == stop_idx) begin
          out_ready = 1'b0; finished = 1;
          return;
        end
        if (hs == stall_idx && left > 0) begin
          out_ready = 1'b0;
          if (left < stall_len && out_data !== held) stall_bad++;
          if (mem_rd_en) stall_bad++;
          held = out_data;
          left--;
        end else begin
          out_ready = 1'b1;
          words.push_back(out_data);
          lasts.push_back(out_last);
          hs++; phs = 1'b1;
        end
      end
      pv = out_valid;
      @(negedge clk);
    end
  endtask

  initial begin
    int errs, nl;
    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 + i;

    // reset state
    #12;
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_rden", mem_rd_en, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);  chk("rst_cksum", checksum, 0);
    @(negedge clk); rst = 1'b1;

    // basic dump of 3 words
    mem[0] = 10; mem[1] = 20; mem[2] = 30;
    do_start(0, 3);
    chk("basic_read_rden", mem_rd_en, 1);
    chk("basic_read_addr", mem_addr, 0);
    chk("basic_read_busy", busy, 1);
    collect(-1, 0, -1);
    chk("basic_fin", finished, 1);
    chk("basic_nwords", words.size(), 3);
    chk("basic_w0", words[0], 10); chk("basic_w1", words[1], 20); chk("basic_w2", words[2], 30);
    chk("basic_last_bits", {lasts[0], lasts[1], lasts[2]}, 3'b001);
    chk("basic_first_valid", first_valid, 2);
    chk("basic_done_cyc", done_cyc, 9);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_busy_after", busy, 0);
    chk("basic_done_after", done, 0);
    chk("basic_cksum", checksum, CK_EN ? 60 : 0);

    // backpressure on word 2 for 5 cycles
    do_start(0, 3);
    collect(1, 5, -1);
    chk("bp_fin", finished, 1);
    chk("bp_stall_bad", stall_bad, 0);
    chk("bp_nreads", rdaddrs.size(), 3);
    chk("bp_nwords", words.size(), 3);
    chk("bp_w0", words[0], 10); chk("bp_w1", words[1], 20); chk("bp_w2", words[2], 30);
    chk("bp_done_cyc", done_cyc, 14);

    // address wrap
    mem[1023] = 7; mem[0] = 8;
    do_start(1023, 2);
    collect(-1, 0, -1);
    chk("wrap_nreads", rdaddrs.size(), 2);
    chk("wrap_a0", rdaddrs[0], 1023); chk("wrap_a1", rdaddrs[1], 0);
    chk("wrap_w0", words[0], 7); chk("wrap_w1", words[1], 8);
    chk("wrap_last", lasts[1], 1);

    // zero count
    do_start(0, 0);
    chk("zero_busy", busy, 1); chk("zero_done", done, 1);
    chk("zero_rden", mem_rd_en, 0); chk("zero_valid", out_valid, 0);
    @(negedge clk);
    chk("zero_busy_after", busy, 0); chk("zero_done_after", done, 0);
    chk("zero_rden_after", mem_rd_en, 0); chk("zero_valid_after", out_valid, 0);

    // reset while holding word 2 of 4
    mem[0] = 11; mem[1] = 22; mem[2] = 33; mem[3] = 44;
    do_start(0, 4);
    collect(-1, 0, 1);
    chk("abort_hold_valid", out_valid, 1);
    chk("abort_hold_data", out_data, 22);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0); chk("abort_data", out_data, 0);
    chk("abort_busy", busy, 0);       chk("abort_last", out_last, 0);
    chk("abort_rden", mem_rd_en, 0);  chk("abort_addr", mem_addr, 0);
    chk("abort_cksum", checksum, 0);
    nl = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) nl++; end
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done || busy) nl++; end
    chk("abort_no_done", nl, 0);

    // start pulsed during WAIT is ignored
    do_start(0, 3);
    @(negedge clk);
    start = 1'b1; base_addr = 10'd2; count = 11'd1;
    @(negedge clk);
    start = 1'b0;
    collect(-1, 0, -1);
    chk("ign_nwords", words.size(), 3);
    chk("ign_w0", words[0], 11); chk("ign_w2", words[2], 33);
    chk("ign_cksum", checksum, CK_EN ? 66 : 0);
    chk("ign_busy_after", busy, 0);

    // whole memory
    for (int i = 0; i < 1024; i++) mem[i] = i;
    do_start(0, 1024);
    collect(-1, 0, -1);
    chk("full_fin", finished, 1);
    chk("full_nwords", words.size(), 1024);
    errs = 0; nl = 0;
    foreach (words[i]) begin
      if (words[i] !== 32'(i)) errs++;
      if (lasts[i]) nl++;
    end
    chk("full_word_errs", errs, 0);
    chk("full_nlast", nl, 1);
    chk("full_last_pos", lasts[1023], 1);
    chk("full_cksum", checksum, CK_EN ? 523776 : 0);
    chk("full_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-back engine for the processor's 1024-word data memory. The load path writes words into memory through an address/data/strobe port; this block works in the other direction. After `start`, it reads a contiguous range of memory words and streams them out on a valid/ready handshake. It sits beside the data memory on the memory's read port and lets a bench or debug host dump results without reaching into the hierarchy.

## Interface
Parameters:
- ADDR_W, 10, memory address width (1024 words)
- DATA_W, 32, memory word width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; captured on accepted start
- count  in  ADDR_W+1  number of words, 0..1024; captured on accepted start
- mem_rd_en  out  1  read strobe to the data memory
- mem_addr  out  ADDR_W  read address to the data memory
- mem_rd_data  in  DATA_W  read data; valid exactly 1 cycle after a mem_rd_en cycle
- out_data  out  DATA_W  streamed word
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high on an edge
- out_last  out  1  high with out_valid on the final word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a dump
- checksum  out  DATA_W  running sum of streamed words (see Configuration)

## Operation
States: IDLE, READ, WAIT, HOLD, DONE.
- **IDLE:** `start`=1 with `count`≠0 captures `base_addr`→addr and `count`→remaining, clears checksum, then goes to READ. `start`=1 with `count`=0 goes straight to DONE and emits no words. `start`=0 stays in IDLE.
- **READ:** `mem_rd_en`=1 and `mem_addr`=addr for one cycle, then WAIT.
- **WAIT:** `mem_rd_data` is registered into `out_data`. `out_last` is set iff remaining==1. Then HOLD.
- **HOLD:** `out_valid`=1. `out_data` and `out_last` are held stable until the handshake.
  - On handshake: remaining decrements, addr increments modulo 2^ADDR_W (1023 wraps to 0), and the checksum is updated.
  - If `out_last` was set, go to DONE; otherwise go to READ.
  - With no handshake, stay in HOLD indefinitely.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarting.
- `count`=1024 with any `base_addr` dumps the whole memory, wrapping around once.
- No memory writes are ever issued.
- `mem_rd_en` is 0 in every state except READ.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - `mem_rd_en`=0, `mem_addr`=0.
  - `out_data`=0, `out_valid`=0, `out_last`=0.
  - `busy`=0, `done`=0, `checksum`=0.
- Reset asserted mid-dump aborts at once. There is no `done` pulse and the partially held word is discarded.
- Start accepted at edge T gives READ in T+1 (`mem_rd_en` high), WAIT in T+2, and `out_valid` high from T+3.
- With `out_ready` held high, each word costs 3 cycles (READ, WAIT, HOLD).
- After the last handshake at edge E, `done` is high during the cycle following E, and `busy` is low in the cycle after that.
- `busy` rises the cycle after the accepted start, including the `count`=0 case, where `busy` and `done` are both high for one cycle.
- `out_valid` never drops without a handshake. `out_data` does not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `MEM_DUMP_CHECKSUM_EN` defined:
  - `checksum` accumulates the 32-bit wrap-around sum of every handshaken word, cleared on accepted start.
  - It holds its final value from the `done` cycle until the next accepted start.
- `MEM_DUMP_CHECKSUM_EN` undefined:
  - No accumulator is built and `checksum` is constant 0.
  - All other behaviour is identical.

## Test plan
- **Basic dump:** preload mem[0..2]=10,20,30; set `base_addr`=0, `count`=3, `out_ready`=1.
  - Required: words 10, 20, 30 appear on `out_data`, `out_last` only on 30.
  - Required: `out_valid` is first high 3 cycles after start, then `done` pulses once.
  - Required (macro defined): `checksum`=60.
- **Backpressure:** same dump with `out_ready`=0 for 5 cycles on word 2.
  - Required: `out_data`=20 holds stable with `out_valid`=1 throughout.
  - Required: no `mem_rd_en` is issued while stalled.
  - Required: the stream completes in order after `out_ready` returns.
- **Wrap:** set mem[1023]=7, mem[0]=8; `base_addr`=1023, `count`=2.
  - Required: `mem_addr` sequence 1023 then 0, and output 7 then 8.
- **Zero count:** `count`=0.
  - Required: no `mem_rd_en` and no `out_valid`.
  - Required: `busy` and `done` both high in the cycle after start, then IDLE.
- **Reset and ignored start:** assert `rst`=0 while in HOLD on word 2 of 4.
  - Required: all outputs go to 0 immediately and there is no `done` pulse.
  - Then a start pulsed during a later dump's WAIT state must be ignored: the dump length is unchanged.
- **Full memory:** preload mem[i]=i and set `count`=1024.
  - Required: 1024 words 0..1023 and a single `out_last`.
  - Required (macro defined): `checksum`=523776; otherwise 0.
